// File: rtl/soc_system_joystick_pkg.sv
// Shared register map, CTRL bit positions and sequencer states for the joystick controller.
package soc_system_joystick_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
  localparam logic [1:0] ADDR_CTRL     = 2'd3;

  localparam int CTRL_ENABLE_BIT     = 0;
  localparam int CTRL_SAMPLE_NOW_BIT = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SAMPLE = 2'd2,
    COMMIT = 2'd3
  } joy_state_e;

endpackage

// File: rtl/soc_system_joystick_debounce.sv
// Synchronizer, sample history, stable counter and commit/edge-capture datapath.
// Sequenced by the top-level FSM through the sample/commit/clear strobes.
module soc_system_joystick_debounce #(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_in_port,
  input  logic        i_sample_en,
  input  logic        i_commit_en,
  input  logic        i_stable_clr,
  input  logic [31:0] i_edge_w1c,
  output logic [31:0] o_data,
  output logic [31:0] o_edge_cap
);
  import soc_system_joystick_pkg::*;

  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_CNT - 1);

  logic [31:0] r_sync1;
  logic [31:0] r_sync2;
  logic [31:0] r_sample;
  logic [3:0]  r_stable_cnt;
  logic [31:0] r_data;
  logic [31:0] r_edge;
  logic        w_commit;
  logic [31:0] w_edge_set;

  assign w_commit   = i_commit_en && (r_stable_cnt == STABLE_MAX) && (r_sample != r_data);
  assign w_edge_set = w_commit ? (r_sample ^ r_data) : 32'h0000_0000;

  // Two-flop synchronizer on the raw pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 32'h0000_0000;
      r_sync2 <= 32'h0000_0000;
    end else begin
      r_sync1 <= i_in_port;
      r_sync2 <= r_sync1;
    end
  end

  // Sample history and saturating run-length of identical samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample     <= 32'h0000_0000;
      r_stable_cnt <= 4'd0;
    end else if (i_stable_clr) begin
      r_stable_cnt <= 4'd0;
    end else if (i_sample_en) begin
      r_sample <= r_sync2;
      if (r_sync2 == r_sample) begin
        if (r_stable_cnt != STABLE_MAX) begin
          r_stable_cnt <= r_stable_cnt + 4'd1;
        end
      end else begin
        r_stable_cnt <= 4'd0;
      end
    end
  end

  // Debounced word and edge capture; a same-cycle set beats the W1C clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= 32'h0000_0000;
      r_edge <= 32'h0000_0000;
    end else begin
      if (w_commit) begin
        r_data <= r_sample;
      end
      r_edge <= (r_edge & ~i_edge_w1c) | w_edge_set;
    end
  end

  assign o_data     = r_data;
  assign o_edge_cap = r_edge;

endmodule

// File: rtl/soc_system_joystick_ctrl.sv
// Joystick sampling/debounce controller: FSM, sample divider and Avalon-MM register file.
// Optional IRQ_MASK register and irq output are built only when JOYSTICK_CTRL_IRQ_EN is defined.
module soc_system_joystick_ctrl #(
  parameter int SAMPLE_DIV   = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_port,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);
  import soc_system_joystick_pkg::*;

  localparam logic [19:0] DIV_LAST = 20'(SAMPLE_DIV - 1);

  joy_state_e  r_state;
  joy_state_e  w_state_nxt;
  logic [19:0] r_div;
  logic        r_enable;
  logic [31:0] r_readdata;
  logic        w_wr_ctrl;
  logic        w_wr_edge;
  logic        w_sample_now;
  logic        w_enable_nxt;
  logic [31:0] w_edge_w1c;
  logic [31:0] w_data;
  logic [31:0] w_edge_cap;
  logic [31:0] w_irq_mask;
  logic        w_unused_read;

  // Reads are unconditional and registered, so the strobe carries no information
  assign w_unused_read = read;

  assign w_wr_ctrl    = write && (address == ADDR_CTRL);
  assign w_wr_edge    = write && (address == ADDR_EDGE_CAP);
  assign w_sample_now = w_wr_ctrl && writedata[CTRL_SAMPLE_NOW_BIT];
  assign w_enable_nxt = w_wr_ctrl ? writedata[CTRL_ENABLE_BIT] : r_enable;
  assign w_edge_w1c   = w_wr_edge ? writedata : 32'h0000_0000;

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; a cleared enable wins everywhere, COMMIT still finishes its write-back
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_enable_nxt) w_state_nxt = COUNT;
        else              w_state_nxt = IDLE;
      end
      COUNT: begin
        if (!w_enable_nxt)                           w_state_nxt = IDLE;
        else if ((r_div == DIV_LAST) || w_sample_now) w_state_nxt = SAMPLE;
        else                                          w_state_nxt = COUNT;
      end
      SAMPLE: begin
        if (!w_enable_nxt) w_state_nxt = IDLE;
        else               w_state_nxt = COMMIT;
      end
      COMMIT: begin
        if (!w_enable_nxt) w_state_nxt = IDLE;
        else               w_state_nxt = COUNT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sample divider runs only while counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= 20'd0;
    end else if (r_state == COUNT) begin
      r_div <= r_div + 20'd1;
    end else begin
      r_div <= 20'd0;
    end
  end

  // CTRL enable bit; sample_now is a pulse and is never stored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_enable <= writedata[CTRL_ENABLE_BIT];
    end
  end

`ifdef JOYSTICK_CTRL_IRQ_EN
  logic [31:0] r_irq_mask;

  // Interrupt mask register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_mask <= 32'h0000_0000;
    end else if (write && (address == ADDR_IRQ_MASK)) begin
      r_irq_mask <= writedata;
    end
  end

  assign w_irq_mask = r_irq_mask;
  assign irq        = |(w_edge_cap & r_irq_mask);
`else
  assign w_irq_mask = 32'h0000_0000;
  assign irq        = 1'b0;
`endif

  soc_system_joystick_debounce #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .i_in_port    (in_port),
    .i_sample_en  (r_state == SAMPLE),
    .i_commit_en  (r_state == COMMIT),
    .i_stable_clr (r_state == IDLE),
    .i_edge_w1c   (w_edge_w1c),
    .o_data       (w_data),
    .o_edge_cap   (w_edge_cap)
  );

  // Registered read mux, refreshed every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata <= 32'h0000_0000;
    end else begin
      case (address)
        ADDR_DATA:     r_readdata <= w_data;
        ADDR_IRQ_MASK: r_readdata <= w_irq_mask;
        ADDR_EDGE_CAP: r_readdata <= w_edge_cap;
        ADDR_CTRL:     r_readdata <= {31'd0, r_enable};
        default:       r_readdata <= 32'h0000_0000;
      endcase
    end
  end

  assign readdata = r_readdata;

endmodule

// File: tb/tb_soc_system_joystick_ctrl.sv
// Self-checking bench for soc_system_joystick_ctrl (SAMPLE_DIV=4, DEBOUNCE_CNT=3).
// Expectations adapt to whether JOYSTICK_CTRL_IRQ_EN is defined.
module tb_soc_system_joystick_ctrl;

`ifdef JOYSTICK_CTRL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_port;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [31:0] in_word;
    logic [31:0] exp_data;
    logic [31:0] exp_edge;
  } vec_t;
  vec_t vecs[5];

  soc_system_joystick_ctrl #(
    .SAMPLE_DIV   (4),
    .DEBOUNCE_CNT (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic expect_push(input string nm, input logic [31:0] e);
    sb_t s;
    s.name = nm;
    s.exp  = e;
    sb_q.push_back(s);
  endtask

  task automatic check_pop(input logic [31:0] act);
    sb_t s;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with no expectation queued", act);
    end else begin
      s = sb_q.pop_front();
      if (act !== s.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", s.name, act, s.exp);
      end
    end
  endtask

  // All tasks start and finish on a falling edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
    writedata = 32'h0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] e, input string nm);
    address = a;
    read    = 1'b1;
    expect_push(nm, e);
    @(negedge clk);
    read    = 1'b0;
    check_pop(readdata);
  endtask

  task automatic irq_chk(input logic e, input string nm);
    expect_push(nm, {31'd0, e});
    check_pop({31'd0, irq});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0005, 32'h0000_0005};
    vecs[1] = '{32'h0000_0004, 32'h0000_0004, 32'h0000_0001};
    vecs[2] = '{32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0B};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5A5A_F0F0};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};

    reset = 1'b1; in_port = 32'h0; address = 2'd0;
    read = 1'b0; write = 1'b0; writedata = 32'h0;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(1);

    rd_chk(2'd0, 32'h0, "reset_data");
    rd_chk(2'd1, 32'h0, "reset_mask");
    rd_chk(2'd2, 32'h0, "reset_edge");
    rd_chk(2'd3, 32'h0, "reset_ctrl");
    irq_chk(1'b0, "reset_irq");

    wr(2'd3, 32'h1);
    rd_chk(2'd3, 32'h1, "ctrl_enable");

    for (int i = 0; i < 5; i++) begin
      wr(2'd2, 32'hFFFF_FFFF);
      in_port = vecs[i].in_word;
      wait_cyc(40);
      rd_chk(2'd0, vecs[i].exp_data, $sformatf("vec%0d_data", i));
      rd_chk(2'd2, vecs[i].exp_edge, $sformatf("vec%0d_edge", i));
      irq_chk(1'b0, $sformatf("vec%0d_irq_unmasked", i));
    end

    // Masked edge raises irq; W1C drops it the next cycle
    wr(2'd1, 32'h1);
    rd_chk(2'd1, IRQ_ON ? 32'h1 : 32'h0, "mask_readback");
    wr(2'd2, 32'hFFFF_FFFF);
    in_port = 32'h0000_0005;
    wait_cyc(40);
    wr(2'd2, 32'hFFFF_FFFF);
    irq_chk(1'b0, "irq_after_clear_all");
    in_port = 32'h0000_0004;
    wait_cyc(40);
    rd_chk(2'd2, 32'h1, "mask_edge_bit0");
    irq_chk(IRQ_ON, "irq_masked_edge");
    wr(2'd2, 32'h1);
    irq_chk(1'b0, "irq_w1c");
    rd_chk(2'd2, 32'h0, "edge_w1c");

    // Bit 0 alternates on every sample: never stable long enough to commit
    for (int i = 0; i < 10; i++) begin
      in_port = in_port ^ 32'h1;
      wait_cyc(6);
    end
    wait_cyc(2);
    rd_chk(2'd0, 32'h4, "bounce_data");
    rd_chk(2'd2, 32'h0, "bounce_edge");

    // Disabled controller ignores the pins; sample_now drives three quick samples
    wr(2'd3, 32'h0);
    in_port = 32'hFFFF_FFFF;
    wait_cyc(40);
    rd_chk(2'd0, 32'h4, "disabled_data_held");
    wr(2'd3, 32'h1);
    wr(2'd3, 32'h3);
    wait_cyc(2);
    wr(2'd3, 32'h3);
    wait_cyc(2);
    wr(2'd3, 32'h3);
    wait_cyc(2);
    rd_chk(2'd0, 32'hFFFF_FFFF, "sample_now_data");
    rd_chk(2'd3, 32'h1, "ctrl_sample_now_reads0");

    // W1C lands in the COMMIT cycle that sets the same bit
    wr(2'd3, 32'h0);
    in_port = 32'hFFFF_FFFE;
    wait_cyc(5);
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd3, 32'h1);
    wr(2'd3, 32'h3);
    wait_cyc(2);
    wr(2'd3, 32'h3);
    wait_cyc(2);
    wr(2'd3, 32'h3);
    wait_cyc(1);
    wr(2'd2, 32'h1);
    rd_chk(2'd2, 32'h1, "collision_set_wins");
    rd_chk(2'd0, 32'hFFFF_FFFE, "collision_data");

    // Reset mid-operation: everything back to zero, no commit afterwards
    in_port = 32'h1234_5678;
    wait_cyc(10);
    reset = 1'b1;
    wait_cyc(1);
    expect_push("reset_async_readdata", 32'h0);
    check_pop(readdata);
    reset = 1'b0;
    wait_cyc(1);
    rd_chk(2'd0, 32'h0, "rst2_data");
    rd_chk(2'd1, 32'h0, "rst2_mask");
    rd_chk(2'd2, 32'h0, "rst2_edge");
    rd_chk(2'd3, 32'h0, "rst2_ctrl");
    irq_chk(1'b0, "rst2_irq");
    wait_cyc(40);
    rd_chk(2'd0, 32'h0, "rst2_no_commit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
